// File: rtl/fib_job_sched_if.sv
// Request/result handshake bundle for the Fibonacci job scheduler.
// The master is the client that queues indices and consumes results; the slave is the scheduler.
interface fib_job_sched_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_n;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_n;
    logic [4:0] out_fib;
    logic       out_err;

    modport master (
        output in_valid, in_n, out_ready,
        input  in_ready, out_valid, out_n, out_fib, out_err
    );

    modport slave (
        input  in_valid, in_n, out_ready,
        output in_ready, out_valid, out_n, out_fib, out_err
    );
endinterface

// File: rtl/fib_job_sched.sv
// Queues Fibonacci indices and runs them one at a time on an external fib core.
// Each job gets a restart pulse, then a bounded wait for done, then holds its result until accepted.
module fib_job_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    fib_job_sched_if.slave        bus,
    output logic                  core_rst,
    output logic [2:0]            core_n,
    input  logic [4:0]            core_out,
    input  logic                  core_done,
    output logic                  busy
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0]      state;
    logic [2:0]      mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CNTW-1:0] count;
    logic [CW-1:0]   cnt;
    logic [2:0]      job_n;
    logic [4:0]      fib_q;
    logic            err_q;

    logic empty;
    logic push;
    logic pop;
    logic done_ok;
    logic timed_out;

    assign empty     = (count == '0);
    assign push      = bus.in_valid && bus.in_ready;
    assign pop       = !empty && ((state == IDLE) || ((state == HOLD) && bus.out_ready));
    // A done seen in the first WAIT cycle may be left over from the previous job.
    assign done_ok   = core_done && (cnt != '0);
    assign timed_out = (cnt == CW'(TIMEOUT));

    assign bus.in_ready  = (count < CNTW'(DEPTH));
    assign bus.out_valid = (state == HOLD);
    assign bus.out_n     = job_n;
    assign bus.out_fib   = fib_q;
    assign bus.out_err   = err_q;
    assign core_rst      = (state == LAUNCH);
    assign busy          = (state != IDLE) || !empty;

    // NOTE: queue storage has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.in_n;
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            cnt    <= '0;
            core_n <= '0;
            job_n  <= '0;
            fib_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);

            if (push && !pop)      count <= count + CNTW'(1);
            else if (pop && !push) count <= count - CNTW'(1);

            if (pop) begin
                core_n <= mem[rptr];
                job_n  <= mem[rptr];
            end

            case (state)
                IDLE: begin
                    if (!empty) state <= LAUNCH;
                end
                LAUNCH: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (done_ok) begin
                        state <= HOLD;
                        fib_q <= core_out;
                        err_q <= 1'b0;
                    end else if (timed_out) begin
                        state <= HOLD;
                        fib_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) state <= empty ? IDLE : LAUNCH;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fib_job_sched.sv
// Directed bench for fib_job_sched with a behavioural fib core of adjustable latency.
// Outputs are sampled on the falling edge; stimulus changes there too.
module tb_fib_job_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       core_rst;
    logic [2:0] core_n;
    logic [4:0] core_out;
    logic       core_done;
    logic       busy;

    fib_job_sched_if bus();

    fib_job_sched #(.DEPTH(4), .TIMEOUT(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .core_rst  (core_rst),
        .core_n    (core_n),
        .core_out  (core_out),
        .core_done (core_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Fibonacci with fib(0) = fib(1) = 1, as the core computes it.
    logic [4:0] fib_tab [8] = '{5'd1, 5'd1, 5'd2, 5'd3, 5'd5, 5'd8, 5'd13, 5'd21};

    // Core model: done rises core_lat edges after the restart pulse; ovr_en forces done.
    int         core_lat   = 1;
    int         core_cnt   = 0;
    logic       model_done = 1'b0;
    logic [4:0] model_out  = '0;
    logic       ovr_en     = 1'b0;
    logic       ovr_val    = 1'b0;

    always @(posedge clk) begin
        if (core_rst) begin
            core_cnt   <= core_lat;
            model_done <= 1'b0;
            model_out  <= '0;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                model_done <= 1'b1;
                model_out  <= fib_tab[core_n];
            end
        end
    end

    assign core_done = ovr_en ? ovr_val : model_done;
    assign core_out  = model_out;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the accepting rising edge.
    task automatic push(input logic [2:0] n);
        int g = 0;
        bus.in_n     = n;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) check("push_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int got;
        int unstable;

        bus.in_valid  = 1'b0;
        bus.in_n      = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy",      busy,          0);
        check("rst_core_rst",  core_rst,      0);
        check("rst_core_n",    core_n,        0);
        check("rst_out_n",     bus.out_n,     0);
        check("rst_out_fib",   bus.out_fib,   0);
        check("rst_out_err",   bus.out_err,   0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Single job n=5, minimum latency of four edges
        bus.in_n     = 3'd5;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("t1_no_launch_on_push", core_rst, 0);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_core_rst", core_rst, 1);
        check("t1_core_n", core_n, 5);
        @(negedge clk);
        check("t1_pulse_one_cycle", core_rst, 0);
        check("t1_core_n_stable", core_n, 5);
        @(negedge clk);
        check("t1_not_valid_yet", bus.out_valid, 0);
        @(negedge clk);
        check("t1_out_valid", bus.out_valid, 1);
        check("t1_out_n", bus.out_n, 5);
        check("t1_out_fib", bus.out_fib, 8);
        check("t1_out_err", bus.out_err, 0);
        @(negedge clk);
        check("t1_valid_drops", bus.out_valid, 0);
        check("t1_idle", busy, 0);

        // Back-to-back 0..7 with results collected in order
        got = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) push(3'(i));
            end
            begin
                k = 0;
                while (got < 8 && k < 300) begin
                    @(negedge clk);
                    k++;
                    if (bus.out_valid) begin
                        check("t2_out_n", bus.out_n, 32'(got));
                        check("t2_out_fib", bus.out_fib, fib_tab[got]);
                        check("t2_out_err", bus.out_err, 0);
                        got++;
                    end
                end
            end
        join
        check("t2_result_count", got, 8);
        @(negedge clk);
        check("t2_idle", busy, 0);

        // Timeout with a silent core, queue fills to DEPTH
        bus.out_ready = 1'b0;
        ovr_en  = 1'b1;
        ovr_val = 1'b0;
        push(3'd3);
        push(3'd4);
        push(3'd5);
        push(3'd6);
        push(3'd7);
        check("t3_full_in_ready", bus.in_ready, 0);
        bus.in_n     = 3'd0;
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.out_valid && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("t3_timeout_valid", bus.out_valid, 1);
        check("t3_timeout_cycles", k, 254);
        check("t3_out_n", bus.out_n, 3);
        check("t3_out_fib", bus.out_fib, 0);
        check("t3_out_err", bus.out_err, 1);
        bus.in_valid = 1'b0;

        // Result held while the consumer stalls
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_n != 3'd3 || bus.out_fib != 5'd0 ||
                !bus.out_err || core_rst)
                unstable++;
        end
        check("t3_hold_stable", unstable, 0);
        check("t3_still_full", bus.in_ready, 0);
        core_lat = 2;
        ovr_en   = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t3_relaunch_same_edge", core_rst, 1);
        check("t3_relaunch_core_n", core_n, 4);
        check("t3_valid_after_accept", bus.out_valid, 0);
        got = 0;
        k = 0;
        while (got < 4 && k < 100) begin
            @(negedge clk);
            k++;
            if (bus.out_valid) begin
                check("t3_q_out_n", bus.out_n, 32'(got + 4));
                check("t3_q_out_fib", bus.out_fib, fib_tab[got + 4]);
                check("t3_q_out_err", bus.out_err, 0);
                got++;
            end
        end
        check("t3_q_count", got, 4);
        @(negedge clk);
        check("t3_no_push_while_full", busy, 0);

        // Stale done at launch must be blanked
        core_lat = 6;
        ovr_en   = 1'b1;
        ovr_val  = 1'b1;
        push(3'd4);
        @(negedge clk);
        check("t4_launch", core_rst, 1);
        @(negedge clk);
        check("t4_wait0_no_valid", bus.out_valid, 0);
        @(negedge clk);
        check("t4_stale_ignored", bus.out_valid, 0);
        ovr_en  = 1'b0;
        ovr_val = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t4_valid", bus.out_valid, 1);
        check("t4_real_done_cycles", k, 6);
        check("t4_out_n", bus.out_n, 4);
        check("t4_out_fib", bus.out_fib, 5);
        check("t4_out_err", bus.out_err, 0);
        @(negedge clk);
        check("t4_idle", busy, 0);

        // Reset during WAIT with two requests queued
        core_lat = 50;
        push(3'd1);
        push(3'd2);
        push(3'd3);
        repeat (2) @(negedge clk);
        check("t5_busy_before", busy, 1);
        check("t5_core_n_before", core_n, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_out_valid", bus.out_valid, 0);
        check("t5_rst_in_ready",  bus.in_ready,  1);
        check("t5_rst_core_rst",  core_rst,      0);
        check("t5_rst_core_n",    core_n,        0);
        check("t5_rst_out_n",     bus.out_n,     0);
        check("t5_rst_out_fib",   bus.out_fib,   0);
        check("t5_rst_out_err",   bus.out_err,   0);
        check("t5_rst_busy",      busy,          0);
        @(negedge clk);
        rst = 1'b1;
        unstable = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.out_valid || core_rst || busy) unstable++;
        end
        check("t5_queue_discarded", unstable, 0);

        // First launch after reset comes one edge after the push
        core_lat     = 1;
        bus.in_n     = 3'd6;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("t5_no_launch_on_push", core_rst, 0);
        check("t5_busy_after_push", busy, 1);
        @(negedge clk);
        check("t5_launch", core_rst, 1);
        check("t5_core_n", core_n, 6);
        k = 0;
        while (!bus.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t5_valid", bus.out_valid, 1);
        check("t5_out_n", bus.out_n, 6);
        check("t5_out_fib", bus.out_fib, 13);
        check("t5_out_err", bus.out_err, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fib_job_sched.md
FIB_JOB_SCHED -- requirements
Module: fib_job_sched

Interface
REQ-001 Parameter DEPTH, default 4: request FIFO entries (power of two, at least 2).
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles before a job is aborted.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-005 in_valid  input  1  request N offered.
REQ-006 in_ready  output  1  FIFO can accept; high exactly when FIFO count < DEPTH.
REQ-007 in_n  input  3  requested Fibonacci index, 0..7.
REQ-008 core_rst  output  1  active-high restart pulse to the fib core.
REQ-009 core_n  output  3  index presented to the fib core.
REQ-010 core_out  input  5  fib core result.
REQ-011 core_done  input  1  fib core completion level.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_n  output  3  index of the reported job.
REQ-015 out_fib  output  5  reported result.
REQ-016 out_err  output  1  job timed out; out_fib is 0 when set.
REQ-017 busy  output  1  high whenever the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-018 A request SHALL be pushed when in_valid and in_ready are both high at a clock edge; requests SHALL be processed in FIFO order.
REQ-019 A push and a pop in the same cycle SHALL leave the count unchanged; a push while full SHALL be impossible because in_ready is low.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH.
REQ-021 FSM states: IDLE, LAUNCH, WAIT, HOLD.
REQ-022 IDLE -> LAUNCH when the FIFO is non-empty; on that edge, pop the head and register it into core_n and into the job-index register.
REQ-023 In LAUNCH, core_rst SHALL be 1 for exactly one cycle; next state is WAIT, and the cycle counter clears to 0.
REQ-024 core_n SHALL hold stable from LAUNCH until the next pop.
REQ-025 In WAIT, the counter SHALL increment every cycle.
REQ-026 core_done SHALL be ignored in the first WAIT cycle (blanking of stale done).
REQ-027 From the second WAIT cycle, core_done=1 -> HOLD, capturing core_out into out_fib and clearing out_err.
REQ-028 If the counter reaches TIMEOUT without an accepted done -> HOLD with out_fib=0 and out_err=1.
REQ-029 If done and timeout occur in the same cycle, done SHALL win (out_err=0).
REQ-030 In HOLD, out_valid=1, and out_n/out_fib/out_err SHALL stay stable until out_ready=1.
REQ-031 On the accepting edge: HOLD -> LAUNCH if the FIFO is non-empty (popping in the same edge), else -> IDLE.
REQ-032 out_valid SHALL be 0 in all states except HOLD.
REQ-033 Minimum latency from push into an empty idle block to out_valid: 1 (IDLE->LAUNCH) + 1 (LAUNCH) + 2 (min WAIT) = 4 edges.
REQ-034 Requests SHALL continue to be accepted in every FSM state while the FIFO is not full.

Reset
REQ-035 While rst=0: FSM=IDLE, FIFO empty, in_ready=1, core_rst=0, core_n=0, out_valid=0, out_n=0, out_fib=0, out_err=0, busy=0, counter=0.
REQ-036 Reset asserted mid-job SHALL discard the job in progress and all queued requests; no result is reported for them.
REQ-037 The first LAUNCH after reset release SHALL occur no earlier than one edge after the first push.

Verification
REQ-038 Push in_n=5 with out_ready=1 and a correct core -> a single core_rst pulse with core_n=5; then out_valid with out_n=5, out_fib=8, out_err=0.
REQ-039 Push 0..7 back-to-back, out_ready=1 -> results in order 1,1,2,3,5,8,13,21, each with out_err=0.
REQ-040 With core_done held 0, push in_n=3 (DEPTH=4) then 4 more pushes -> in_ready drops after 4 queued entries; after TIMEOUT+1 WAIT cycles, out_n=3, out_fib=0, out_err=1.
REQ-041 Hold out_ready=0 for 20 cycles in HOLD -> outputs stable and no new core_rst; out_ready=1 -> next LAUNCH on the same edge if the FIFO is non-empty.
REQ-042 Stale done: core_done already 1 at LAUNCH and dropping in the first WAIT cycle -> not accepted; HOLD entered only on the core's later done.
REQ-043 Assert rst=0 during WAIT with 2 entries queued -> all outputs at reset values immediately; after release, no out_valid until a new push.
